id_ex_stage: RTL and testbench

//  ID/EX pipeline stage. Sits directly downstream of the decode/regfile stage (data_id).

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/id_ex_stage_if.sv | 68 ++++++
 rtl/id_ex_stage_fwd_unit.sv | 33 +++
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared types for the ID/EX stage slice.
//   - XZR       : register number of the zero register; never forwarded/hazarded
//   - alu_op_e  : 3-bit ALU operation encoding carried in the control word
//   - ctrl_t    : packed control word travelling down the pipe with the instr
//   - rd_match  : "producer writes a real register that equals src" helper
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_RSVD   = 3'd1,
        ALU_ADD    = 3'd2,
        ALU_SUB    = 3'd3,
        ALU_AND    = 3'd4,
        ALU_OR     = 3'd5,
        ALU_XOR    = 3'd6,
        ALU_PASS_A = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic    RegWrite;
        logic    MemWrite;
        logic    MemtoReg;
        logic    ALUsrc;
        alu_op_e ALUop;
        logic    update_flags;
        logic    BLsignal;
        logic    UnCondBr;
        logic    BrTaken;
    } ctrl_t;

    // A producer only matches when it actually writes and the target is not
    // XZR; writes to XZR are architecturally discarded.
    function automatic logic rd_match(input logic       wr_en,
                                      input logic [4:0] rd,
                                      input logic [4:0] src);
        return wr_en && (rd != XZR) && (rd == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
//   Bundle of all non-clock signals around the ID/EX stage.
//   ID side      : id_valid, id_Da/Db, id_ALU_or_DT, id_BR_to_shift, id_pc,
//                  id_Rn/Ab/Rd, id_uses_Ab, id_ctrl, flush
//   Producers    : mem_RegWrite/Rd/result (EX/MEM), wb_RegWrite/Rd/result (MEM/WB)
//   EX side      : ex_valid, ex_ctrl, ex_A/B, ex_imm, ex_br_off, ex_pc, ex_Rd
//   Status       : stall (IF/ID hold), bubble_cnt
//   Modports: master = surrounding pipeline, slave = the ID/EX stage.
// ----------------------------------------------------------------------------
interface id_ex_stage_if
    import cpu_pkg::*;
#(
    parameter int W     = 64,
    parameter int CNT_W = 32
) ();

    // ID side
    logic             id_valid;
    logic [W-1:0]     id_Da;
    logic [W-1:0]     id_Db;
    logic [W-1:0]     id_ALU_or_DT;
    logic [W-1:0]     id_BR_to_shift;
    logic [W-1:0]     id_pc;
    logic [4:0]       id_Rn;
    logic [4:0]       id_Ab;
    logic [4:0]       id_Rd;
    logic             id_uses_Ab;
    ctrl_t            id_ctrl;
    logic             flush;

    // downstream producers
    logic             mem_RegWrite;
    logic [4:0]       mem_Rd;
    logic [W-1:0]     mem_result;
    logic             wb_RegWrite;
    logic [4:0]       wb_Rd;
    logic [W-1:0]     wb_result;

    // EX side
    logic             ex_valid;
    ctrl_t            ex_ctrl;
    logic [W-1:0]     ex_A;
    logic [W-1:0]     ex_B;
    logic [W-1:0]     ex_imm;
    logic [W-1:0]     ex_br_off;
    logic [W-1:0]     ex_pc;
    logic [4:0]       ex_Rd;
    logic             stall;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_Da, id_Db, id_ALU_or_DT, id_BR_to_shift, id_pc,
               id_Rn, id_Ab, id_Rd, id_uses_Ab, id_ctrl, flush,
               mem_RegWrite, mem_Rd, mem_result, wb_RegWrite, wb_Rd, wb_result,
        input  ex_valid, ex_ctrl, ex_A, ex_B, ex_imm, ex_br_off, ex_pc, ex_Rd,
               stall, bubble_cnt
    );

    modport slave (
        input  id_valid, id_Da, id_Db, id_ALU_or_DT, id_BR_to_shift, id_pc,
               id_Rn, id_Ab, id_Rd, id_uses_Ab, id_ctrl, flush,
               mem_RegWrite, mem_Rd, mem_result, wb_RegWrite, wb_Rd, wb_result,
        output ex_valid, ex_ctrl, ex_A, ex_B, ex_imm, ex_br_off, ex_pc, ex_Rd,
               stall, bubble_cnt
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// ----------------------------------------------------------------------------
// fwd_unit
//   Operand forwarding mux for one EX source operand.
//   Ports: src_i (source reg number), reg_val_i (value captured at ID/EX),
//          mem_* (EX/MEM producer), wb_* (MEM/WB producer), val_o (operand).
//   Priority: EX/MEM (youngest) > MEM/WB > captured value. XZR never matches.
// ----------------------------------------------------------------------------
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [4:0]   src_i,
    input  logic [W-1:0] reg_val_i,
    input  logic         mem_RegWrite_i,
    input  logic [4:0]   mem_Rd_i,
    input  logic [W-1:0] mem_result_i,
    input  logic         wb_RegWrite_i,
    input  logic [4:0]   wb_Rd_i,
    input  logic [W-1:0] wb_result_i,
    output logic [W-1:0] val_o
);

    always_comb begin
        val_o = reg_val_i;
        if (rd_match(mem_RegWrite_i, mem_Rd_i, src_i)) begin
            val_o = mem_result_i;
        end else if (rd_match(wb_RegWrite_i, wb_Rd_i, src_i)) begin
            val_o = wb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection, flush squash,
//   capture-time WB bypass and EX-time operand forwarding.
//   Ports: clk, reset (sync, active high), io (id_ex_stage_if.slave).
//   stall is combinational and holds PC + IF/ID; on stall or flush a bubble
//   (valid=0, ctrl=0, Rd=XZR) enters EX. bubble_cnt counts load-use bubbles
//   and saturates at all-ones.
// ----------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int W     = 64,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    id_ex_stage_if.slave       io
);

    localparam int NUM_OPS = 2;  // operand A (Rn) and operand B (Ab)

    logic             valid_q, valid_d;
    ctrl_t            ctrl_q,  ctrl_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [W-1:0]     imm_q,   imm_d;
    logic [W-1:0]     br_q,    br_d;
    logic [W-1:0]     pc_q,    pc_d;
    logic [4:0]       rd_q,    rd_d;
    logic [4:0]       rn_q,    rn_d;
    logic [4:0]       ab_q,    ab_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             hz;
    logic             stall_w;

    // Load in EX whose destination is read by the instruction in ID: the
    // value is not available until MEM, so one bubble is required.
    always_comb begin
        hz = valid_q && ctrl_q.MemtoReg && ctrl_q.RegWrite && (rd_q != XZR) &&
             ((rd_q == io.id_Rn) || (io.id_uses_Ab && (rd_q == io.id_Ab))) &&
             io.id_valid;
        // Flush discards the ID instruction anyway, so no hold; reset masks it
        // so the upstream never sees a hold during reset.
        stall_w = hz && !io.flush && !reset;
    end

    always_comb begin
        // normal capture; regfile write-while-read is covered by the WB bypass
        valid_d = io.id_valid;
        ctrl_d  = io.id_valid ? io.id_ctrl : ctrl_t'('0);
        a_d     = rd_match(io.wb_RegWrite, io.wb_Rd, io.id_Rn) ? io.wb_result : io.id_Da;
        b_d     = rd_match(io.wb_RegWrite, io.wb_Rd, io.id_Ab) ? io.wb_result : io.id_Db;
        imm_d   = io.id_ALU_or_DT;
        br_d    = io.id_BR_to_shift;
        pc_d    = io.id_pc;
        rd_d    = io.id_Rd;
        rn_d    = io.id_Rn;
        ab_d    = io.id_Ab;
        cnt_d   = cnt_q;

        if (io.flush || stall_w) begin
            // Source regs parked on XZR so a bubble can never pick up a
            // forwarded value.
            valid_d = 1'b0;
            ctrl_d  = ctrl_t'('0);
            a_d     = '0;
            b_d     = '0;
            imm_d   = '0;
            br_d    = '0;
            pc_d    = '0;
            rd_d    = XZR;
            rn_d    = XZR;
            ab_d    = XZR;
        end

        if (stall_w && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= ctrl_t'('0);
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            br_q    <= '0;
            pc_q    <= '0;
            rd_q    <= XZR;
            rn_q    <= XZR;
            ab_q    <= XZR;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            br_q    <= br_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            ab_q    <= ab_d;
            cnt_q   <= cnt_d;
        end
    end

    // forwarding, one unit per operand
    logic [NUM_OPS-1:0][4:0]   op_src;
    logic [NUM_OPS-1:0][W-1:0] op_reg;
    logic [NUM_OPS-1:0][W-1:0] op_fwd;

    assign op_src = {ab_q, rn_q};
    assign op_reg = {b_q,  a_q};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        fwd_unit #(.W(W)) u_fwd (
            .src_i          (op_src[g]),
            .reg_val_i      (op_reg[g]),
            .mem_RegWrite_i (io.mem_RegWrite),
            .mem_Rd_i       (io.mem_Rd),
            .mem_result_i   (io.mem_result),
            .wb_RegWrite_i  (io.wb_RegWrite),
            .wb_Rd_i        (io.wb_Rd),
            .wb_result_i    (io.wb_result),
            .val_o          (op_fwd[g])
        );
    end

    assign io.ex_valid   = valid_q;
    assign io.ex_ctrl    = ctrl_q;
    assign io.ex_A       = op_fwd[0];
    assign io.ex_B       = op_fwd[1];
    assign io.ex_imm     = imm_q;
    assign io.ex_br_off  = br_q;
    assign io.ex_pc      = pc_q;
    assign io.ex_Rd      = rd_q;
    assign io.stall      = stall_w;
    assign io.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Expected EX contents are queued when the ID
// side is driven and popped after the capturing edge.
module tb_id_ex_stage;
    import cpu_pkg::*;

    localparam int W     = 64;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.W(W), .CNT_W(CNT_W)) io ();

    id_ex_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    typedef struct {
        logic        valid;
        ctrl_t       ctrl;
        logic [4:0]  rd;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic        chk_data;
    } exp_t;

    exp_t sbq[$];
    int vectors    = 0;
    int miscompares = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    ctrl_t LD_C, ADD_C;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_prod();
        io.mem_RegWrite = 1'b0; io.mem_Rd = 5'd0; io.mem_result = '0;
        io.wb_RegWrite  = 1'b0; io.wb_Rd  = 5'd0; io.wb_result  = '0;
        io.flush = 1'b0;
    endtask

    task automatic drive(input logic v, input ctrl_t c, input logic [4:0] rn, input logic [4:0] ab,
                         input logic [4:0] rd, input logic ua, input logic [63:0] da,
                         input logic [63:0] db, input logic [63:0] imm);
        io.id_valid = v; io.id_ctrl = c; io.id_Rn = rn; io.id_Ab = ab; io.id_Rd = rd;
        io.id_uses_Ab = ua; io.id_Da = da; io.id_Db = db; io.id_ALU_or_DT = imm;
        io.id_BR_to_shift = imm << 2; io.id_pc = 64'h1000;
        #1;
    endtask

    // expected result of a normal capture of what is on the ID side now
    task automatic push_cap();
        exp_t e;
        e.valid = io.id_valid;
        e.ctrl  = io.id_valid ? io.id_ctrl : ctrl_t'('0);
        e.rd    = io.id_Rd;
        e.a = (io.wb_RegWrite && io.wb_Rd != 5'd31 && io.wb_Rd == io.id_Rn) ? io.wb_result : io.id_Da;
        e.b = (io.wb_RegWrite && io.wb_Rd != 5'd31 && io.wb_Rd == io.id_Ab) ? io.wb_result : io.id_Db;
        e.imm = io.id_ALU_or_DT;
        e.chk_data = 1'b1;
        sbq.push_back(e);
    endtask

    task automatic push_bubble(input logic data_zero);
        exp_t e;
        e.valid = 1'b0; e.ctrl = ctrl_t'('0); e.rd = 5'd31;
        e.a = '0; e.b = '0; e.imm = '0; e.chk_data = data_zero;
        sbq.push_back(e);
    endtask

    task automatic tick_pop(input string tag);
        exp_t e;
        @(posedge clk); #1;
        clr_prod();
        #1;
        if (sbq.size() == 0) begin
            chk({tag, "_sbq_empty"}, 64'd0, 64'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_valid"}, 64'(io.ex_valid), 64'(e.valid));
            chk({tag, "_ctrl"},  64'(io.ex_ctrl),  64'(e.ctrl));
            chk({tag, "_rd"},    64'(io.ex_Rd),    64'(e.rd));
            if (e.chk_data) begin
                chk({tag, "_A"},   io.ex_A,   e.a);
                chk({tag, "_B"},   io.ex_B,   e.b);
                chk({tag, "_imm"}, io.ex_imm, e.imm);
            end
            chk({tag, "_cnt"}, 64'(io.bubble_cnt), 64'(exp_cnt));
        end
    endtask

    initial begin
        LD_C = '0; LD_C.RegWrite = 1'b1; LD_C.MemtoReg = 1'b1; LD_C.ALUsrc = 1'b1; LD_C.ALUop = ALU_ADD;
        ADD_C = '0; ADD_C.RegWrite = 1'b1; ADD_C.ALUop = ALU_ADD; ADD_C.update_flags = 1'b1;

        // 1. reset with a valid instruction on ID
        reset = 1'b1;
        clr_prod();
        drive(1'b1, ADD_C, 5'd1, 5'd2, 5'd3, 1'b1, 64'h11, 64'h22, 64'h5);
        push_bubble(1'b1);
        tick_pop("rst0");
        chk("rst0_stall", 64'(io.stall), 64'd0);
        push_bubble(1'b1);
        tick_pop("rst1");
        chk("rst1_stall", 64'(io.stall), 64'd0);
        reset = 1'b0;

        // 2. load-use: LDUR X3 then ADD X2,X3,X4
        drive(1'b1, LD_C, 5'd1, 5'd31, 5'd3, 1'b0, 64'h100, 64'h0, 64'h8);
        chk("ld_stall", 64'(io.stall), 64'd0);
        push_cap();
        tick_pop("ld");
        drive(1'b1, ADD_C, 5'd3, 5'd4, 5'd2, 1'b1, 64'h0, 64'h44, 64'h0);
        chk("lu_stall", 64'(io.stall), 64'd1);
        push_bubble(1'b0); exp_cnt++;
        tick_pop("lu_bub");
        // re-presented ADD; loaded X3 now writing back -> capture bypass
        io.wb_RegWrite = 1'b1; io.wb_Rd = 5'd3; io.wb_result = 64'h55;
        #1;
        chk("lu_restall", 64'(io.stall), 64'd0);
        push_cap();
        tick_pop("lu_add");

        // 3. same hazard with flush
        drive(1'b1, LD_C, 5'd1, 5'd31, 5'd3, 1'b0, 64'h100, 64'h0, 64'h8);
        push_cap();
        tick_pop("ld2");
        drive(1'b1, ADD_C, 5'd3, 5'd4, 5'd2, 1'b1, 64'h0, 64'h44, 64'h0);
        io.flush = 1'b1; #1;
        chk("fl_stall", 64'(io.stall), 64'd0);
        push_bubble(1'b0);
        tick_pop("fl_bub");

        // 4. EX forwarding priority
        drive(1'b1, ADD_C, 5'd5, 5'd6, 5'd7, 1'b1, 64'h11, 64'h22, 64'h0);
        push_cap();
        tick_pop("fw_cap");
        drive(1'b0, ADD_C, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0, 64'h0, 64'h0);
        io.mem_RegWrite = 1'b1; io.mem_Rd = 5'd5; io.mem_result = 64'hAA;
        io.wb_RegWrite  = 1'b1; io.wb_Rd  = 5'd5; io.wb_result  = 64'hBB;
        #1;
        chk("fw_mem_A", io.ex_A, 64'hAA);
        chk("fw_mem_B", io.ex_B, 64'h22);
        io.mem_RegWrite = 1'b0; #1;
        chk("fw_wb_A", io.ex_A, 64'hBB);
        io.mem_RegWrite = 1'b1; io.mem_Rd = 5'd6; io.mem_result = 64'hCC; #1;
        chk("fw_memB_A", io.ex_A, 64'hBB);
        chk("fw_memB_B", io.ex_B, 64'hCC);
        clr_prod(); #1;
        chk("fw_none_A", io.ex_A, 64'h11);

        // 5. XZR sources and loads to XZR
        drive(1'b1, ADD_C, 5'd31, 5'd31, 5'd7, 1'b1, 64'h0, 64'h0, 64'h0);
        push_cap();
        tick_pop("z_cap");
        io.mem_RegWrite = 1'b1; io.mem_Rd = 5'd31; io.mem_result = 64'd69;
        io.wb_RegWrite  = 1'b1; io.wb_Rd  = 5'd31; io.wb_result  = 64'd70;
        #1;
        chk("z_A", io.ex_A, 64'd0);
        chk("z_B", io.ex_B, 64'd0);
        clr_prod();
        drive(1'b1, LD_C, 5'd1, 5'd31, 5'd31, 1'b0, 64'h100, 64'h0, 64'h8);
        push_cap();
        tick_pop("zld");
        drive(1'b1, ADD_C, 5'd31, 5'd31, 5'd2, 1'b1, 64'h0, 64'h0, 64'h0);
        chk("zld_stall", 64'(io.stall), 64'd0);
        push_cap();
        tick_pop("zld_add");
        // Ab match ignored when the instruction does not read Ab
        drive(1'b1, LD_C, 5'd1, 5'd31, 5'd9, 1'b0, 64'h100, 64'h0, 64'h8);
        push_cap();
        tick_pop("ld9");
        drive(1'b1, ADD_C, 5'd1, 5'd9, 5'd2, 1'b0, 64'h7, 64'h0, 64'h3);
        chk("noab_stall", 64'(io.stall), 64'd0);
        push_cap();
        tick_pop("noab");

        // 6. capture-time WB bypass
        drive(1'b1, ADD_C, 5'd8, 5'd4, 5'd2, 1'b1, 64'h0, 64'h44, 64'h0);
        io.wb_RegWrite = 1'b1; io.wb_Rd = 5'd8; io.wb_result = 64'd69; #1;
        push_cap();
        tick_pop("wbbyp");
        chk("wbbyp_A", io.ex_A, 64'd69);

        // counter saturation: one bubble per LDUR/consumer pair
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, LD_C, 5'd1, 5'd31, 5'd9, 1'b0, 64'h100, 64'h0, 64'h8);
            push_cap();
            tick_pop("sat_ld");
            if (i % 2 == 0)
                drive(1'b1, ADD_C, 5'd9, 5'd4, 5'd2, 1'b1, 64'h0, 64'h0, 64'h0);
            else
                drive(1'b1, ADD_C, 5'd4, 5'd9, 5'd2, 1'b1, 64'h0, 64'h0, 64'h0);
            chk("sat_stall", 64'(io.stall), 64'd1);
            push_bubble(1'b0);
            if (exp_cnt != {CNT_W{1'b1}}) exp_cnt++;
            tick_pop("sat_bub");
        end
        chk("sat_final", 64'(io.bubble_cnt), 64'hF);

        // reset during a stall
        drive(1'b1, LD_C, 5'd1, 5'd31, 5'd9, 1'b0, 64'h100, 64'h0, 64'h8);
        push_cap();
        tick_pop("rs_ld");
        drive(1'b1, ADD_C, 5'd9, 5'd4, 5'd2, 1'b1, 64'h0, 64'h0, 64'h0);
        chk("rs_pre_stall", 64'(io.stall), 64'd1);
        reset = 1'b1; #1;
        chk("rs_stall", 64'(io.stall), 64'd0);
        push_bubble(1'b1); exp_cnt = '0;
        tick_pop("rs");
        reset = 1'b0;
        #1;
        chk("rs_post_stall", 64'(io.stall), 64'd0);
        push_cap();
        tick_pop("rs_next");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
